// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants for the register write arbiter: byte-lane rw encoding and default sizes.
package reg_write_arbiter_pkg;

  localparam int RW_W = 2;

  localparam logic [RW_W-1:0] LANE_NONE = 2'b00;
  localparam logic [RW_W-1:0] LANE_LO   = 2'b01;
  localparam logic [RW_W-1:0] LANE_HI   = 2'b10;
  localparam logic [RW_W-1:0] LANE_ALL  = 2'b11;

  localparam int SIZE_DEF = 16;
  localparam int NREG_DEF = 8;

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[(int'(ptr) + i) % N]) begin
        found                    = 1'b1;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx                      = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the shared register-file write bus with registered data/rw outputs.
// Optional macro ARB_LOCK_EN adds req_lock so a requester can keep priority across transfers.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SIZE = SIZE_DEF,
  parameter int NREG = NREG_DEF,
  parameter int REGW = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*REGW-1:0]   req_dst,
  input  logic [NREQ*RW_W-1:0]   req_lane,
  input  logic [NREQ*SIZE-1:0]   req_data,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]        req_lock,
`endif
  output logic [NREQ-1:0]        gnt,
  output logic [SIZE-1:0]        bus_data,
  output logic [NREG*RW_W-1:0]   reg_rw,
  output logic                   busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a transfer happens at the rising edge where req[k] & gnt[k];
  // the requester holds req and payload stable until then and may drop after.
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        win_idx;
  logic [NREQ-1:0]      win_gnt;
  logic                 xfer;
  logic                 lock_hit;
  logic [SIZE-1:0]      sel_data;
  logic [REGW-1:0]      sel_dst;
  logic [RW_W-1:0]      sel_lane;
  logic [SIZE-1:0]      bus_data_q, bus_data_d;
  logic [NREG*RW_W-1:0] reg_rw_q, reg_rw_d;
  logic                 busy_q, busy_d;

  rr_arbiter #(.N(NREQ), .IW(PW)) u_rr (
    .req (req),
    .ptr (ptr_q),
    .en  (rst_n & ~hold),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign gnt  = win_gnt;
  assign xfer = |win_gnt;

`ifdef ARB_LOCK_EN
  assign lock_hit = |(win_gnt & req_lock);
`else
  assign lock_hit = 1'b0;
`endif

  // One-hot mux of the winner's payload.
  always_comb begin
    sel_data = '0;
    sel_dst  = '0;
    sel_lane = LANE_NONE;
    for (int k = 0; k < NREQ; k++) begin
      if (win_gnt[k]) begin
        sel_data = req_data[k*SIZE +: SIZE];
        sel_dst  = req_dst[k*REGW +: REGW];
        sel_lane = req_lane[k*RW_W +: RW_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (lock_hit) ptr_d = win_idx;
      else if (win_idx == PW'(NREQ - 1)) ptr_d = '0;
      else ptr_d = win_idx + 1'b1;
    end
  end

  // Out-of-range destinations match no field, so they are consumed without a write.
  always_comb begin
    bus_data_d = bus_data_q;
    reg_rw_d   = '0;
    busy_d     = 1'b0;
    if (xfer) begin
      bus_data_d = sel_data;
      for (int r = 0; r < NREG; r++) begin
        if (sel_dst == REGW'(r)) begin
          reg_rw_d[r*RW_W +: RW_W] = sel_lane;
          busy_d                   = (sel_lane != LANE_NONE);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      bus_data_q <= '0;
      reg_rw_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      bus_data_q <= bus_data_d;
      reg_rw_q   <= reg_rw_d;
      busy_q     <= busy_d;
    end
  end

  assign bus_data = bus_data_q;
  assign reg_rw   = reg_rw_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: reference model feeds an expected-output queue.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int SIZE = 16;
  localparam int NREG = 8;
  localparam int REGW = 3;
  localparam int OW   = 1 + NREG*2 + SIZE;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 hold = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*REGW-1:0] req_dst = '0;
  logic [NREQ*2-1:0]    req_lane = '0;
  logic [NREQ*SIZE-1:0] req_data = '0;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]      req_lock = '0;
`endif
  logic [NREQ-1:0]      gnt;
  logic [SIZE-1:0]      bus_data;
  logic [NREG*2-1:0]    reg_rw;
  logic                 busy;

  reg_write_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .NREG(NREG), .REGW(REGW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .req      (req),
    .req_dst  (req_dst),
    .req_lane (req_lane),
    .req_data (req_data),
`ifdef ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .gnt      (gnt),
    .bus_data (bus_data),
    .reg_rw   (reg_rw),
    .busy     (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // bench state
  int n_checks = 0;
  int n_errors = 0;
  logic [OW-1:0]   exp_q[$];
  logic [NREQ-1:0] pend = '0;
  int              dst_a[NREQ];
  logic [1:0]      lane_a[NREQ];
  logic [SIZE-1:0] data_a[NREQ];
  int              m_ptr = 0;
  logic [SIZE-1:0] m_bus = '0;
  logic [NREG*2-1:0] m_rw = '0;
  logic            m_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int k, input int dst, input logic [1:0] lane, input logic [SIZE-1:0] d);
    pend[k]   = 1'b1;
    dst_a[k]  = dst;
    lane_a[k] = lane;
    data_a[k] = d;
  endtask

  task automatic drive();
    req = pend;
    for (int k = 0; k < NREQ; k++) begin
      req_dst[k*REGW +: REGW]  = REGW'(dst_a[k]);
      req_lane[k*2 +: 2]       = lane_a[k];
      req_data[k*SIZE +: SIZE] = data_a[k];
    end
  endtask

  // One clock: check combinational grant, push expected registered result, compare after the edge.
  task automatic step();
    logic [NREQ-1:0] eg;
    logic [OW-1:0]   ex;
    int              ei;
    drive();
    #1;
    eg = '0;
    ei = -1;
    if (rst_n && !hold)
      for (int i = 0; i < NREQ; i++)
        if (ei < 0 && req[(m_ptr + i) % NREQ]) ei = (m_ptr + i) % NREQ;
    if (ei >= 0) eg[ei] = 1'b1;
    check("gnt", 64'(gnt), 64'(eg));
    if (!rst_n) begin
      m_bus = '0; m_rw = '0; m_busy = 1'b0; m_ptr = 0;
    end else if (ei >= 0) begin
      m_bus  = data_a[ei];
      m_rw   = '0;
      m_busy = 1'b0;
      if (dst_a[ei] < NREG) begin
        m_rw[dst_a[ei]*2 +: 2] = lane_a[ei];
        m_busy = (lane_a[ei] != LANE_NONE);
      end
      m_ptr = (ei + 1) % NREQ;
`ifdef ARB_LOCK_EN
      if (req_lock[ei]) m_ptr = ei;
`endif
      pend[ei] = 1'b0;
    end else begin
      m_rw = '0; m_busy = 1'b0;
    end
    exp_q.push_back({m_busy, m_rw, m_bus});
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      check("outputs", 64'({busy, reg_rw, bus_data}), 64'(ex));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      dst_a[k] = 0; lane_a[k] = LANE_NONE; data_a[k] = '0;
    end
    @(negedge clk);
    do_reset();
    check("rst_bus", 64'(bus_data), 64'(0));
    check("rst_rw", 64'(reg_rw), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // 1: single request
    set_req(0, 3, LANE_ALL, 16'h1234);
    step();
    check("t1_rw", 64'(reg_rw), 64'(16'h00C0));
    check("t1_bus", 64'(bus_data), 64'(16'h1234));
    check("t1_busy", 64'(busy), 64'(1));
    step();

    // 2: round robin from reset
    do_reset();
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < NREQ; k++) set_req(k, k, LANE_LO, 16'(16'h100 * (c + 1) + k));
      step();
    end
    pend = '0;
    step();

    // 3: lanes
    set_req(2, 0, LANE_LO, 16'h89AB);
    step();
    check("t3_lo", 64'(reg_rw), 64'(16'h0001));
    set_req(2, 0, LANE_HI, 16'hCDEF);
    step();
    check("t3_hi", 64'(reg_rw), 64'(16'h0002));
    set_req(2, 0, LANE_NONE, 16'h5555);
    step();
    check("t3_none_busy", 64'(busy), 64'(0));
    step();

    // 4: hold
    set_req(0, 1, LANE_ALL, 16'hAAAA);
    set_req(1, 2, LANE_ALL, 16'hBBBB);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) step();
    hold = 1'b0;
    step();
    step();
    step();

    // 5: reset mid-stream with pointer at 2
    do_reset();
    set_req(0, 4, LANE_ALL, 16'h0A0A);
    set_req(1, 5, LANE_ALL, 16'h0B0B);
    step();
    step();
    set_req(2, 6, LANE_HI, 16'h0C0C);
    set_req(3, 7, LANE_LO, 16'h0D0D);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();

`ifdef ARB_LOCK_EN
    // 6: lock keeps requester 0 for a three-word sequence
    do_reset();
    req_lock = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req_lock = '0;
      set_req(0, c, LANE_ALL, 16'(16'hE000 + c));
      set_req(1, 7, LANE_ALL, 16'hF00F);
      step();
    end
    step();
    pend = '0;
    step();
`endif

    // random traffic with held requests
    do_reset();
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < NREQ; k++)
        if (!pend[k] && $urandom_range(0, 2) == 0)
          set_req(k, $urandom_range(0, NREG - 1), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));
      hold = ($urandom_range(0, 7) == 0);
      step();
    end
    hold = 1'b0;
    pend = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single internal write bus among NREQ requesters (ALU writeback, load unit, immediate loader, debug port) that target the 16-bit byte-lane register file.
- Each cycle it picks one requester round-robin and drives the shared bus data.
- It also drives the 2-bit byte-lane rw strobe of exactly one destination register; all other registers get rw=00.
- Sits between the execution units and the register bank; the bank's rw encoding (01 low byte, 10 high byte, 11 full word, 00 hold) is used unchanged.

Parameters:
NREQ, 4, number of requesters (2..8)
SIZE, 16, data width; must be even
NREG, 8, number of destination registers
REGW, 3, destination index width, ceil(log2(NREG))

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
hold  input  1  pipeline freeze: no new grants while high
req  input  NREQ  per-requester request
req_dst  input  NREQ*REGW  destination register index, requester k in bits [k*REGW +: REGW]
req_lane  input  NREQ*2  byte-lane select per requester, same encoding as register rw
req_data  input  NREQ*SIZE  write data per requester
gnt  output  NREQ  one-hot grant, combinational in the request cycle
bus_data  output  SIZE  registered shared write data
reg_rw  output  NREG*2  registered rw strobes, register r in bits [r*2 +: 2]
busy  output  1  registered; high when reg_rw carries a write this cycle

Behaviour:
- Reset: when rst_n is low at a rising edge, the following apply.
  - bus_data=0, reg_rw=0, busy=0.
  - Round-robin pointer is set to 0, so requester 0 has highest priority next.
  - While rst_n is low, gnt is forced to 0.
  - Requests pending during reset are not lost; requesters keep req high and are re-arbitrated after reset.
- Handshake:
  - A requester raises req with its payload (dst, lane, data) stable and keeps it until it samples gnt=1.
  - A transfer occurs at the edge where req[k] & gnt[k] are both 1.
  - req may drop only after the transfer.
- Arbitration:
  - gnt is combinational from req, hold and the registered pointer.
  - The grant goes to the first k with req[k]=1, searching from the pointer upward and wrapping modulo NREQ.
  - At most one gnt bit is set; gnt=0 if no request, if hold=1, or if reset is active.
- Pointer:
  - On a transfer from k, the pointer becomes (k+1) mod NREQ.
  - With no transfer, the pointer is unchanged.
- Latency: one cycle. At the edge after the transfer, the following are valid for one cycle.
  - bus_data = granted req_data.
  - reg_rw[dst] = granted lane; all other fields are 00.
  - busy = (lane != 00).
- No-transfer cycle: reg_rw=0 and busy=0 next cycle; bus_data holds its last value.
- lane=00 request: granted and consumed normally, but produces no write (reg_rw all 00, busy=0).
- dst >= NREG: consumed, no write.
- Back-to-back transfers, including to the same register, are allowed one per cycle with no bubble.
- hold: suppresses new grants only. A transfer accepted in the previous cycle still appears on the outputs.
- Simultaneous hold and reset: reset wins.
- Fairness: any requester held high is granted within NREQ transfer cycles.

Optional Feature:
ARB_LOCK_EN
- With the macro defined, an extra input port req_lock (NREQ) is present.
- If the current transfer is from k with req_lock[k]=1, the pointer stays at k instead of advancing.
- k therefore keeps priority for its next cycle, allowing atomic multi-word sequences, e.g. a high byte then a low byte.
- Lock ends on the first transfer with req_lock[k]=0, or when req[k] drops.
- hold still blocks grants while a lock is active; reset clears it.
- Without the macro, req_lock does not exist and the pointer always advances as above.

Decomposition:
- Shared package holds:
  - lane constants LANE_NONE=2'b00, LANE_LO=2'b01, LANE_HI=2'b10, LANE_ALL=2'b11;
  - the rw field width constant (2);
  - defaults for SIZE and NREG.
- One sub-module: rr_arbiter (parameter N; inputs req, ptr, en; output one-hot gnt and encoded index).
  - Purely combinational.
  - The pointer register lives in reg_write_arbiter.

Test Plan:
1. Single request: req=0001, dst=3, lane=11, data=16'h1234 -> gnt=0001 same cycle; next cycle reg_rw[7:6]=11, all others 00, bus_data=1234, busy=1.
2. Round-robin: req=1111 held for 4 cycles from reset -> gnt sequence 0001,0010,0100,1000; a fifth cycle gives 0001.
3. Lanes: requester 2 with lane=01 then lane=10 to dst=0, data 89AB then CDEF -> reg_rw[1:0]=01 with bus_data=89AB, then 10 with CDEF; lane=00 -> busy=0, reg_rw=0.
4. hold: req=0011 and hold=1 for 3 cycles -> gnt=0, outputs idle after the in-flight transfer drains; hold=0 -> gnt=0001.
5. Reset mid-stream: pointer at 2, rst_n=0 for one edge with req=1100 -> outputs zero, gnt=0 during reset; after release gnt=0100.
6. ARB_LOCK_EN: req=0011, req_lock=0001 for 3 transfers -> gnt=0001 ×3; lock released -> next grant 0010.
